// File: rtl/writeback_unit_pkg.sv
// Shared control-bus bit layout, load-size encodings and the latched
// instruction record used by the writeback stage.
`ifndef CONTROL_VH
`define CONTROL_VH
`define RWE            0
`define RDST           1
`define MEMTOREG       2
`define LDSIZE         3:4
`define LDUNS          5
`define CNTRL_REG_SIZE 5
`endif

package writeback_unit_pkg;

    // 2'b11 is reserved and behaves exactly like a word load.
    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10,
        LD_RSVD = 2'b11
    } ld_size_t;

    typedef struct packed {
        logic        rwe;
        ld_size_t    ld_size;
        logic        ld_uns;
        logic [0:1]  offset;
        logic [0:4]  dest;
    } pending_t;

    function automatic logic [0:31] extend_half(input logic [0:15] value,
                                                input logic        uns);
        return uns ? {16'h0000, value} : {{16{value[0]}}, value};
    endfunction

    function automatic logic [0:31] extend_byte(input logic [0:7] value,
                                                input logic       uns);
        return uns ? {24'h000000, value} : {{24{value[0]}}, value};
    endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// Big-endian sub-word extraction and alignment check for load data.
module load_align
    import writeback_unit_pkg::*;
(
    input  logic [0:31] word,
    input  logic [0:1]  offset,
    input  ld_size_t    size,
    input  logic        uns,
    output logic [0:31] data,
    output logic        misaligned
);

    logic [0:15] sel_half;
    logic [0:7]  sel_byte;

    always_comb begin
        sel_half = offset[0] ? word[16:31] : word[0:15];
        case (offset)
            2'd0:    sel_byte = word[0:7];
            2'd1:    sel_byte = word[8:15];
            2'd2:    sel_byte = word[16:23];
            default: sel_byte = word[24:31];
        endcase
    end

    // Halves only need the low address bit clear; words need both clear.
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (size)
            LD_HALF: begin
                data       = extend_half(sel_half, uns);
                misaligned = offset[1];
            end
            LD_BYTE: begin
                data       = extend_byte(sel_byte, uns);
            end
            default: begin
                data       = word;
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: accepts ALU results or loads from MEM, waits for load
// data, aligns it and issues a single-cycle register-file write.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [0:`CNTRL_REG_SIZE]  control,
    input  logic [0:4]                rtIn,
    input  logic [0:4]                rdIn,
    input  logic [0:31]               aluResult,
    input  logic [0:31]               memData,
    input  logic                      memDataValid,
    output logic                      regWriteEnable,
    output logic [0:4]                regDest,
    output logic [0:31]               writeBackData,
    output logic                      alignError
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_COMMIT    = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LOAD_WAIT = ST_LOAD_WAIT,
        COMMIT    = ST_COMMIT
    } state_t;

    state_t      state, state_next;
    pending_t    pend, pend_next;
    logic        we_next, align_next;
    logic [0:4]  dest_next;
    logic [0:31] data_next;

    logic        transfer;
    logic [0:4]  in_dest;
    logic [0:31] load_data;
    logic        load_misaligned;

    assign inReady  = (state != LOAD_WAIT);
    assign transfer = inValid & inReady;
    assign in_dest  = control[`RDST] ? rdIn : rtIn;

    load_align u_load_align (
        .word       (memData),
        .offset     (pend.offset),
        .size       (pend.ld_size),
        .uns        (pend.ld_uns),
        .data       (load_data),
        .misaligned (load_misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            pend           <= '0;
            regWriteEnable <= 1'b0;
            alignError     <= 1'b0;
            regDest        <= '0;
            writeBackData  <= '0;
        end else begin
            state          <= state_next;
            pend           <= pend_next;
            regWriteEnable <= we_next;
            alignError     <= align_next;
            regDest        <= dest_next;
            writeBackData  <= data_next;
        end
    end

    // Outputs are registered on entry to COMMIT so they last exactly one cycle;
    // data and destination otherwise hold their last committed values.
    always_comb begin
        state_next = state;
        pend_next  = pend;
        we_next    = 1'b0;
        align_next = 1'b0;
        dest_next  = regDest;
        data_next  = writeBackData;

        case (state)
            LOAD_WAIT: begin
                if (memDataValid) begin
                    state_next = COMMIT;
                    we_next    = pend.rwe & (pend.dest != 5'd0) & ~load_misaligned;
                    align_next = load_misaligned;
                    dest_next  = pend.dest;
                    if (!load_misaligned) begin
                        data_next = load_data;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                if (transfer) begin
                    pend_next.rwe     = control[`RWE];
                    pend_next.ld_size = ld_size_t'(control[`LDSIZE]);
                    pend_next.ld_uns  = control[`LDUNS];
                    pend_next.offset  = aluResult[30:31];
                    pend_next.dest    = in_dest;
                    if (control[`MEMTOREG]) begin
                        state_next = LOAD_WAIT;
                    end else begin
                        state_next = COMMIT;
                        we_next    = control[`RWE] & (in_dest != 5'd0);
                        dest_next  = in_dest;
                        data_next  = aluResult;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed corner cases plus random
// ALU/load traffic checked against a behavioural model.
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [0:5]  control;
    logic [0:4]  rtIn;
    logic [0:4]  rdIn;
    logic [0:31] aluResult;
    logic [0:31] memData;
    logic        memDataValid;
    logic        regWriteEnable;
    logic [0:4]  regDest;
    logic [0:31] writeBackData;
    logic        alignError;

    typedef struct {
        bit          has_event;
        bit          align;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_ok;
    int   checks = 0;
    int   fails  = 0;

    writeback_unit dut (
        .clock          (clock),
        .reset          (reset),
        .inValid        (inValid),
        .inReady        (inReady),
        .control        (control),
        .rtIn           (rtIn),
        .rdIn           (rdIn),
        .aluResult      (aluResult),
        .memData        (memData),
        .memDataValid   (memDataValid),
        .regWriteEnable (regWriteEnable),
        .regDest        (regDest),
        .writeBackData  (writeBackData),
        .alignError     (alignError)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, required the test to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // What the register file should see for one instruction, from the rules alone.
    function automatic exp_t model(input bit rwe, input bit rdst, input bit m2r,
                                   input logic [1:0] sz, input bit uns,
                                   input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [31:0] alu, input logic [31:0] mem);
        exp_t        e;
        int unsigned off;
        logic [31:0] v;
        bit          mis;
        off = alu % 4;
        mis = 1'b0;
        v   = alu;
        if (m2r) begin
            if (sz == 2'b01) begin
                v   = (mem >> (16 * (1 - off / 2))) & 32'h0000FFFF;
                mis = (off % 2) != 0;
                if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
            end else if (sz == 2'b10) begin
                v = (mem >> (8 * (3 - off))) & 32'h000000FF;
                if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
            end else begin
                v   = mem;
                mis = off != 0;
            end
        end
        e.dest      = rdst ? rd : rt;
        e.data      = v;
        e.align     = mis;
        e.has_event = mis || (rwe && e.dest != 5'd0);
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && (regWriteEnable !== 1'b0 || alignError !== 1'b0)) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_event: we=%b align=%b dest=%0d data=%h, expected no event",
                         regWriteEnable, alignError, regDest, writeBackData);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.align)
                    mon_ok = (alignError === 1'b1) && (regWriteEnable === 1'b0);
                else
                    mon_ok = (regWriteEnable === 1'b1) && (alignError === 1'b0) &&
                             (regDest === mon_e.dest) && (writeBackData === mon_e.data);
                if (!mon_ok) begin
                    fails++;
                    $display("[TB] FAIL scoreboard: got we=%b align=%b dest=%0d data=%h, expected align=%b dest=%0d data=%h",
                             regWriteEnable, alignError, regDest, writeBackData,
                             mon_e.align, mon_e.dest, mon_e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        inValid      = 1'b0;
        memDataValid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic apply_stimulus(input bit rwe, input bit rdst, input bit m2r,
                                  input logic [1:0] sz, input bit uns,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [31:0] alu, input logic [31:0] mem,
                                  input int wait_cycles, output int stalls);
        exp_t e;
        control      = {rwe, rdst, m2r, sz, uns};
        rtIn         = rt;
        rdIn         = rd;
        aluResult    = alu;
        inValid      = 1'b1;
        memDataValid = 1'($urandom_range(0, 1));
        memData      = $urandom;
        stalls       = 0;
        while (inReady !== 1'b1 && stalls < 200) begin
            @(negedge clock);
            stalls++;
        end
        if (stalls >= 200) begin
            check_output("accept_timeout", 32'(inReady), 32'd1);
            inValid = 1'b0;
            return;
        end
        e = model(rwe, rdst, m2r, sz, uns, rt, rd, alu, mem);
        if (e.has_event) sb.push_back(e);
        @(negedge clock);
        inValid      = 1'b0;
        memDataValid = 1'b0;
        if (m2r) begin
            repeat (wait_cycles) begin
                check_output("ready_low_in_wait", 32'(inReady), 32'd0);
                @(negedge clock);
            end
            memDataValid = 1'b1;
            memData      = mem;
            @(negedge clock);
            memDataValid = 1'b0;
        end
    endtask

    initial begin
        int st;
        reset        = 1'b1;
        inValid      = 1'b0;
        memDataValid = 1'b0;
        control      = '0;
        rtIn         = '0;
        rdIn         = '0;
        aluResult    = '0;
        memData      = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_output("reset_we",    32'(regWriteEnable), 32'd0);
        check_output("reset_align", 32'(alignError),     32'd0);
        check_output("reset_dest",  32'(regDest),        32'd0);
        check_output("reset_data",  writeBackData,       32'd0);
        check_output("reset_ready", 32'(inReady),        32'd1);

        $display("[TB] directed: ALU op to rd");
        apply_stimulus(1, 1, 0, 2'b00, 0, 5'd3, 5'd2, 32'hdeeddeed, 32'h0, 0, st);
        check_output("alu_we",   32'(regWriteEnable), 32'd1);
        check_output("alu_dest", 32'(regDest),        32'd2);
        check_output("alu_data", writeBackData,       32'hdeeddeed);
        idle(1);
        check_output("alu_single_cycle", 32'(regWriteEnable), 32'd0);

        $display("[TB] directed: back-to-back ALU ops");
        apply_stimulus(1, 0, 0, 2'b00, 0, 5'd5, 5'd0, 32'h11111111, 32'h0, 0, st);
        check_output("b2b_stall0", 32'(st), 32'd0);
        check_output("b2b_dest5",  32'(regDest), 32'd5);
        apply_stimulus(1, 0, 0, 2'b00, 0, 5'd7, 5'd0, 32'h22222222, 32'h0, 0, st);
        check_output("b2b_stall1", 32'(st), 32'd0);
        check_output("b2b_dest7",  32'(regDest), 32'd7);
        apply_stimulus(1, 0, 0, 2'b00, 0, 5'd9, 5'd0, 32'h33333333, 32'h0, 0, st);
        check_output("b2b_stall2", 32'(st), 32'd0);
        check_output("b2b_dest9",  32'(regDest), 32'd9);
        check_output("b2b_we",     32'(regWriteEnable), 32'd1);
        idle(1);

        $display("[TB] directed: byte loads");
        apply_stimulus(1, 0, 1, 2'b10, 0, 5'd4, 5'd0, 32'h00001001, 32'h12F45678, 3, st);
        check_output("lb_we",   32'(regWriteEnable), 32'd1);
        check_output("lb_data", writeBackData,       32'hFFFFFFF4);
        apply_stimulus(1, 0, 1, 2'b10, 1, 5'd4, 5'd0, 32'h00001001, 32'h12F45678, 3, st);
        check_output("lbu_data", writeBackData, 32'h000000F4);
        idle(1);

        $display("[TB] directed: half and misaligned word loads");
        apply_stimulus(1, 0, 1, 2'b01, 0, 5'd6, 5'd0, 32'h00000002, 32'hAAAA8001, 1, st);
        check_output("lh_data", writeBackData, 32'hFFFF8001);
        apply_stimulus(1, 0, 1, 2'b00, 0, 5'd6, 5'd0, 32'h00000002, 32'h01020304, 0, st);
        check_output("lw_mis_align", 32'(alignError),     32'd1);
        check_output("lw_mis_we",    32'(regWriteEnable), 32'd0);
        idle(1);
        check_output("align_single_cycle", 32'(alignError), 32'd0);

        $display("[TB] directed: write to R0");
        apply_stimulus(1, 0, 0, 2'b00, 0, 5'd0, 5'd8, 32'h55555555, 32'h0, 0, st);
        check_output("r0_we", 32'(regWriteEnable), 32'd0);
        idle(1);

        $display("[TB] directed: reset during load wait");
        control   = 6'b101000;
        rtIn      = 5'd10;
        rdIn      = 5'd0;
        aluResult = 32'h0;
        inValid   = 1'b1;
        @(negedge clock);
        inValid = 1'b0;
        repeat (2) @(negedge clock);
        reset        = 1'b1;
        memDataValid = 1'b1;
        memData      = 32'hCAFEBABE;
        @(negedge clock);
        reset        = 1'b0;
        memDataValid = 1'b0;
        check_output("rst_wait_we",    32'(regWriteEnable), 32'd0);
        check_output("rst_wait_dest",  32'(regDest),        32'd0);
        check_output("rst_wait_data",  writeBackData,       32'd0);
        check_output("rst_wait_ready", 32'(inReady),        32'd1);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            bit          m2r;
            logic [1:0]  sz;
            m2r = ($urandom_range(0, 2) == 0);
            sz  = 2'($urandom_range(0, 3));
            apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), m2r,
                           sz, 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                           $urandom, $urandom, $urandom_range(0, 3), st);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
